mult_control_param: RTL and testbench

MULT_CONTROL_PARAM -- requirements
Module: mult_control_param

---
 rtl/mult_ctrl_pkg.sv | 28 ++
 rtl/mult_step_counter.sv | 45 ++++
 rtl/mult_control_param.sv | 137 +++++++++++++
 tb/tb_mult_control_param.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Purpose: shared state encodings and width helpers for the sliced-multiplier controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR  = 3'd3
    } state_e;

    // Slice-index width: enough bits to name K slices, never narrower than 1.
    function automatic int sel_width(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

    // Shift width: largest shift is (K-1)+(K-1) = 2K-2 slice units.
    function automatic int shift_width(input int k);
        return (k < 2) ? 1 : $clog2(2 * k - 1);
    endfunction

    // Step-counter width: K*K partial products are visited in order.
    function automatic int step_width(input int k);
        return (k < 2) ? 1 : $clog2(k * k);
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Purpose: step counter walking the K*K partial products, wraps at K*K-1.
// Latency: count updates on the clock edge after clr_i/en_i; last_o is combinational.
// Backpressure: none; clr_i has priority over en_i.
module mult_step_counter
    import mult_ctrl_pkg::*;
#(
    parameter int K  = 2,
    parameter int CW = step_width(K)
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] k_o,
    output logic          last_o
);

    localparam logic [CW-1:0] LAST_K = CW'(K * K - 1);

    logic [CW-1:0] k_q;
    logic [CW-1:0] k_d;

    // Next count: clear wins, otherwise advance and wrap after the final product.
    always_comb begin
        k_d = k_q;
        if (clr_i) begin
            k_d = '0;
        end else if (en_i) begin
            k_d = (k_q == LAST_K) ? '0 : k_q + 1'b1;
        end
    end

    // Count register; reset returns to step 0 without waiting for a clock.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k_o    = k_q;
    assign last_o = (k_q == LAST_K);

endmodule

// File: rtl/mult_control_param.sv
// Purpose: sequencing FSM for a sliced multiplier; steers slice selects and shift per step.
// Latency: start sampled in IDLE -> K*K CALC cycles -> done in cycle K*K+1.
// Backpressure: none; start during CALC or DONE aborts into ERR, start in ERR restarts.
module mult_control_param
    import mult_ctrl_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  SLICE = 4,
    localparam int K     = WIDTH / SLICE,
    localparam int SELW  = sel_width(K),
    localparam int SHW   = shift_width(K)
) (
    input  logic            clk,
    input  logic            reset_a,
    input  logic            start,
    output logic            done,
    output logic            clk_ena,
    output logic            sclr_n,
    output logic [SELW-1:0] input_sel_a,
    output logic [SELW-1:0] input_sel_b,
    output logic [SHW-1:0]  shift_sel,
    output logic            busy,
    output logic            err,
    output logic [2:0]      state_out
);

    localparam int            CW   = step_width(K);
    localparam logic [CW-1:0] K_CW = CW'(K);

    // A configuration that does not split evenly, or has a single slice, is meaningless.
    generate
        if (((WIDTH % SLICE) != 0) || (K < 2)) begin : g_bad_cfg
            $error("mult_control_param: WIDTH must be a multiple of SLICE with WIDTH/SLICE >= 2");
        end
    endgenerate

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] k;
    logic          k_last;
    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] k_mod;
    logic [CW-1:0] k_div;
    logic [CW:0]   sh_sum;

    mult_step_counter #(
        .K  (K),
        .CW (CW)
    ) u_step (
        .clk     (clk),
        .reset_a (reset_a),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .k_o     (k),
        .last_o  (k_last)
    );

    // Step k maps to slice a = k mod K, slice b = k div K; shift is their sum.
    assign k_mod  = k % K_CW;
    assign k_div  = k / K_CW;
    assign sh_sum = {1'b0, k_mod} + {1'b0, k_div};

    // Next state and all outputs; quiet defaults, and held quiet while reset is low.
    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        clk_ena     = 1'b0;
        sclr_n      = 1'b1;
        input_sel_a = '0;
        input_sel_b = '0;
        shift_sel   = '0;
        busy        = 1'b0;
        err         = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        if (reset_a) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sclr_n  = 1'b0;
                        clk_ena = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    busy = 1'b1;
                    if (start) begin
                        state_d = ST_ERR;
                    end else begin
                        clk_ena     = 1'b1;
                        input_sel_a = k_mod[SELW-1:0];
                        input_sel_b = k_div[SELW-1:0];
                        shift_sel   = sh_sum[SHW-1:0];
                        cnt_en      = 1'b1;
                        if (k_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_ERR;
                    end else begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    err = 1'b1;
                    if (start) begin
                        sclr_n  = 1'b0;
                        clk_ena = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_CALC;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register; reset forces IDLE immediately, even mid-sequence.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_mult_control_param.sv
// Purpose: directed self-checking bench for mult_control_param at K=2 and K=4.
// Latency: checks done in cycle K*K+1 after start is sampled.
// Backpressure: exercises start-driven aborts into ERR and restarts.
module tb_mult_control_param;

    logic clk = 1'b0;
    logic reset_a = 1'b0;

    // K = 2 instance: SELW = 1, SHW = 2
    logic       start8 = 1'b0;
    logic       done8, ena8, sclr8, busy8, err8;
    logic       sa8, sb8;
    logic [1:0] sh8;
    logic [2:0] st8;

    // K = 4 instance: SELW = 2, SHW = 3
    logic       start16 = 1'b0;
    logic       done16, ena16, sclr16, busy16, err16;
    logic [1:0] sa16, sb16;
    logic [2:0] sh16;
    logic [2:0] st16;

    int n_cmp  = 0;
    int n_fail = 0;

    // Hand-computed step tables: a = k mod K, b = k div K, shift = a + b
    logic       a8_tab  [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       b8_tab  [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] sh8_tab [4]  = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic [1:0] a16_tab [16] = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3};
    logic [1:0] b16_tab [16] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3};
    logic [2:0] sh16_tab[16] = '{0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6};

    always #5 clk = ~clk;

    mult_control_param #(.WIDTH(8), .SLICE(4)) dut8 (
        .clk(clk), .reset_a(reset_a), .start(start8), .done(done8),
        .clk_ena(ena8), .sclr_n(sclr8), .input_sel_a(sa8), .input_sel_b(sb8),
        .shift_sel(sh8), .busy(busy8), .err(err8), .state_out(st8)
    );

    mult_control_param #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .reset_a(reset_a), .start(start16), .done(done16),
        .clk_ena(ena16), .sclr_n(sclr16), .input_sel_a(sa16), .input_sel_b(sb16),
        .shift_sel(sh16), .busy(busy16), .err(err16), .state_out(st16)
    );

    // Field order: {state, done, clk_ena, sclr_n, busy, err, sel_a, sel_b, shift}
    function automatic logic [11:0] e8(input logic [2:0] st, input logic d, input logic en,
                                       input logic sc, input logic bs, input logic er,
                                       input logic a, input logic b, input logic [1:0] sh);
        return {st, d, en, sc, bs, er, a, b, sh};
    endfunction

    function automatic logic [14:0] e16(input logic [2:0] st, input logic d, input logic en,
                                        input logic sc, input logic bs, input logic er,
                                        input logic [1:0] a, input logic [1:0] b, input logic [2:0] sh);
        return {st, d, en, sc, bs, er, a, b, sh};
    endfunction

    function automatic logic [11:0] obs8();
        return {st8, done8, ena8, sclr8, busy8, err8, sa8, sb8, sh8};
    endfunction

    function automatic logic [14:0] obs16();
        return {st16, done16, ena16, sclr16, busy16, err16, sa16, sb16, sh16};
    endfunction

    // Walk the four CALC steps, the DONE cycle and the return to IDLE on the K=2 instance.
    task automatic run_calc8(input string tag);
        logic [11:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); start8 = 1'b0; #1;
            exp = e8(3'd1, 0, 1, 1, 1, 0, a8_tab[i], b8_tab[i], sh8_tab[i]);
            n_cmp++;
            if (obs8() !== exp) begin
                n_fail++;
                $display("FAIL %s calc step %0d: got %h required %h", tag, i, obs8(), exp);
            end
        end
        @(negedge clk); #1;
        exp = e8(3'd2, 1, 0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL %s done: got %h required %h", tag, obs8(), exp);
        end
        @(negedge clk); #1;
        exp = e8(3'd0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL %s back to idle: got %h required %h", tag, obs8(), exp);
        end
    endtask

    task automatic test_reset();
        logic [11:0] exp8;
        logic [14:0] exp16;
        reset_a = 1'b0;
        start8  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        exp8 = e8(3'd0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp8) begin
            n_fail++;
            $display("FAIL reset k2 with start high: got %h required %h", obs8(), exp8);
        end
        exp16 = e16(3'd0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0);
        n_cmp++;
        if (obs16() !== exp16) begin
            n_fail++;
            $display("FAIL reset k4: got %h required %h", obs16(), exp16);
        end
        start8 = 1'b0;
        #1 reset_a = 1'b1;
    endtask

    task automatic test_basic8();
        logic [11:0] exp;
        @(negedge clk); start8 = 1'b1; #1;
        exp = e8(3'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL basic idle start: got %h required %h", obs8(), exp);
        end
        run_calc8("basic");
    endtask

    task automatic test_width16();
        logic [14:0] exp;
        @(negedge clk); start16 = 1'b1; #1;
        exp = e16(3'd0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0);
        n_cmp++;
        if (obs16() !== exp) begin
            n_fail++;
            $display("FAIL k4 idle start: got %h required %h", obs16(), exp);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); start16 = 1'b0; #1;
            exp = e16(3'd1, 0, 1, 1, 1, 0, a16_tab[i], b16_tab[i], sh16_tab[i]);
            n_cmp++;
            if (obs16() !== exp) begin
                n_fail++;
                $display("FAIL k4 calc step %0d: got %h required %h", i, obs16(), exp);
            end
        end
        @(negedge clk); #1;
        exp = e16(3'd2, 1, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0);
        n_cmp++;
        if (obs16() !== exp) begin
            n_fail++;
            $display("FAIL k4 done in cycle 17: got %h required %h", obs16(), exp);
        end
        @(negedge clk); #1;
        exp = e16(3'd0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0);
        n_cmp++;
        if (obs16() !== exp) begin
            n_fail++;
            $display("FAIL k4 back to idle: got %h required %h", obs16(), exp);
        end
    endtask

    task automatic test_calc_abort();
        logic [11:0] exp;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); #1;
        exp = e8(3'd1, 0, 1, 1, 1, 0, 1, 0, 2'd1);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL abort step 1: got %h required %h", obs8(), exp);
        end
        @(negedge clk); start8 = 1'b1; #1;
        exp = e8(3'd1, 0, 0, 1, 1, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL abort start at step 2: got %h required %h", obs8(), exp);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); start8 = 1'b0; #1;
            exp = e8(3'd3, 0, 0, 1, 0, 1, 0, 0, 2'd0);
            n_cmp++;
            if (obs8() !== exp) begin
                n_fail++;
                $display("FAIL err hold cycle %0d: got %h required %h", i, obs8(), exp);
            end
        end
        @(negedge clk); start8 = 1'b1; #1;
        exp = e8(3'd3, 0, 1, 0, 0, 1, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL err restart: got %h required %h", obs8(), exp);
        end
        run_calc8("restart from err");
    endtask

    task automatic test_done_abort();
        logic [11:0] exp;
        @(negedge clk); start8 = 1'b1;
        repeat (4) begin
            @(negedge clk); start8 = 1'b0;
        end
        @(negedge clk); start8 = 1'b1; #1;
        exp = e8(3'd2, 0, 0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL start in done: got %h required %h", obs8(), exp);
        end
        @(negedge clk); start8 = 1'b0; #1;
        exp = e8(3'd3, 0, 0, 1, 0, 1, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL err after done: got %h required %h", obs8(), exp);
        end
        @(negedge clk); start8 = 1'b1;
        run_calc8("recover from err");
    endtask

    task automatic test_async_reset();
        logic [11:0] exp;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); #1;
        exp = e8(3'd1, 0, 1, 1, 1, 0, 1, 0, 2'd1);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL pre-reset step 1: got %h required %h", obs8(), exp);
        end
        #2 reset_a = 1'b0;
        #1;
        exp = e8(3'd0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL immediate async reset: got %h required %h", obs8(), exp);
        end
        @(negedge clk); #2 reset_a = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL idle after reset release: got %h required %h", obs8(), exp);
        end
        start8 = 1'b1;
        run_calc8("after reset");
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        @(negedge clk); start8 = 1'b1;
        run_calc8("b2b first");
        start8 = 1'b1; #1;
        exp = e8(3'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (obs8() !== exp) begin
            n_fail++;
            $display("FAIL b2b idle start: got %h required %h", obs8(), exp);
        end
        run_calc8("b2b second");
    endtask

    initial begin
        test_reset();
        test_basic8();
        test_width16();
        test_calc_abort();
        test_done_abort();
        test_async_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
